mem_access_unit: RTL and testbench

//  Memory-stage access sequencer of the multicycle CPU; sits directly upstream of the load data extender.

---
 rtl/mem_access_unit_pkg.sv | 47 ++++
 rtl/mem_lane_gen.sv | 50 +++++
 rtl/mem_access_unit.sv | 172 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage access sequencer: opcodes, access sizes, FSM states.
// Opcode helpers are the single point of truth for load/store classification.
package mem_access_unit_pkg;

  localparam logic [5:0] o_lb  = 6'h20;
  localparam logic [5:0] o_lh  = 6'h21;
  localparam logic [5:0] o_lw  = 6'h23;
  localparam logic [5:0] o_lbu = 6'h24;
  localparam logic [5:0] o_lhu = 6'h25;
  localparam logic [5:0] o_sb  = 6'h28;
  localparam logic [5:0] o_sh  = 6'h29;
  localparam logic [5:0] o_sw  = 6'h2b;

  typedef enum logic [1:0] {sz_none = 2'd0, sz_b = 2'd1, sz_h = 2'd2, sz_w = 2'd3} acc_size_e;

  typedef enum logic [1:0] {s_idle = 2'd0, s_req = 2'd1, s_done = 2'd2} state_e;

  function automatic acc_size_e opcode_size(input logic [5:0] op);
    acc_size_e sz;
    case (op)
      o_lw, o_sw:        sz = sz_w;
      o_lh, o_lhu, o_sh: sz = sz_h;
      o_lb, o_lbu, o_sb: sz = sz_b;
      default:           sz = sz_none;
    endcase
    return sz;
  endfunction

  function automatic logic opcode_is_store(input logic [5:0] op);
    logic st;
    case (op)
      o_sw, o_sh, o_sb: st = 1'b1;
      default:          st = 1'b0;
    endcase
    return st;
  endfunction

  function automatic logic opcode_is_load(input logic [5:0] op);
    logic ld;
    case (op)
      o_lw, o_lh, o_lhu, o_lb, o_lbu: ld = 1'b1;
      default:                        ld = 1'b0;
    endcase
    return ld;
  endfunction

endpackage

// File: rtl/mem_lane_gen.sv
// Combinational lane decoder: byte enables, replicated store data and alignment check
// derived from the opcode and the low address bits.
module mem_lane_gen
  import mem_access_unit_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign,
  output logic        is_load,
  output logic        is_store
);

  acc_size_e size_s;

  // Size-dependent lane selection and alignment rule
  always_comb begin
    size_s   = opcode_size(opcode);
    is_load  = opcode_is_load(opcode);
    is_store = opcode_is_store(opcode);
    be       = 4'b0000;
    wdata    = 32'h0000_0000;
    misalign = 1'b0;
    case (size_s)
      sz_w: begin
        be       = 4'b1111;
        wdata    = wdata_in;
        misalign = (addr_lo != 2'b00);
      end
      sz_h: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{wdata_in[15:0]}};
        misalign = addr_lo[0];
      end
      sz_b: begin
        be       = 4'b0001 << addr_lo;
        wdata    = {4{wdata_in[7:0]}};
        misalign = 1'b0;
      end
      default: begin
        be       = 4'b0000;
        wdata    = 32'h0000_0000;
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access sequencer: issues one registered req/ack transaction per accepted start,
// latches load data as the MDR, and reports misalignment and memory timeouts with done.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_in,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic        timeout_err,
  output logic [31:0] mdr_out,
  output logic [3:0]  be_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Counter holds completed wait cycles; the last REQ cycle is reached at TIMEOUT-1.
  localparam logic [CW-1:0] cnt_last = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] cnt_one  = CW'(1);

  logic [3:0]  lane_be_s;
  logic [31:0] lane_wdata_s;
  logic        lane_misalign_s, is_load_s, is_store_s, accept_s;

  mem_lane_gen u_lane (
    .opcode   (opcode),
    .addr_lo  (addr[1:0]),
    .wdata_in (wdata_in),
    .be       (lane_be_s),
    .wdata    (lane_wdata_s),
    .misalign (lane_misalign_s),
    .is_load  (is_load_s),
    .is_store (is_store_s)
  );

  state_e        state_r, state_s;
  logic [CW-1:0] wait_cnt_r, wait_cnt_s;
  logic          busy_r, busy_s, done_r, done_s, mis_r, mis_s, tmo_r, tmo_s;
  logic [31:0]   mdr_r, mdr_s, mem_wdata_r, mem_wdata_s;
  logic [3:0]    be_out_r, be_out_s, mem_be_r, mem_be_s;
  logic          mem_req_r, mem_req_s, mem_we_r, mem_we_s;
  logic [29:0]   mem_addr_r, mem_addr_s;

  assign accept_s = start && (state_r == s_idle) && (is_load_s || is_store_s);

  // Next-state and next-output computation; everything holds unless a transition says otherwise
  always_comb begin
    state_s     = state_r;
    wait_cnt_s  = wait_cnt_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    mis_s       = 1'b0;
    tmo_s       = 1'b0;
    mdr_s       = mdr_r;
    be_out_s    = be_out_r;
    mem_req_s   = mem_req_r;
    mem_we_s    = mem_we_r;
    mem_addr_s  = mem_addr_r;
    mem_be_s    = mem_be_r;
    mem_wdata_s = mem_wdata_r;
    case (state_r)
      s_idle: begin
        if (accept_s) begin
          busy_s = 1'b1;
          if (lane_misalign_s) begin
            state_s = s_done;
            done_s  = 1'b1;
            mis_s   = 1'b1;
          end else begin
            state_s     = s_req;
            wait_cnt_s  = '0;
            mem_req_s   = 1'b1;
            mem_we_s    = is_store_s;
            mem_addr_s  = addr[31:2];
            mem_be_s    = lane_be_s;
            mem_wdata_s = lane_wdata_s;
          end
        end else begin
          state_s = s_idle;
        end
      end
      s_req: begin
        if (mem_ack) begin
          state_s   = s_done;
          mem_req_s = 1'b0;
          done_s    = 1'b1;
          if (!mem_we_r) begin
            mdr_s    = mem_rdata;
            be_out_s = mem_be_r;
          end else begin
            mdr_s    = mdr_r;
          end
        end else if (wait_cnt_r == cnt_last) begin
          state_s   = s_done;
          mem_req_s = 1'b0;
          done_s    = 1'b1;
          tmo_s     = 1'b1;
        end else begin
          wait_cnt_s = wait_cnt_r + cnt_one;
        end
      end
      s_done: begin
        state_s = s_idle;
        busy_s  = 1'b0;
      end
      default: begin
        state_s   = s_idle;
        busy_s    = 1'b0;
        mem_req_s = 1'b0;
      end
    endcase
  end

  // State and registered-output update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= s_idle;
      wait_cnt_r  <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      mis_r       <= 1'b0;
      tmo_r       <= 1'b0;
      mdr_r       <= 32'h0000_0000;
      be_out_r    <= 4'b0000;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 30'h0000_0000;
      mem_be_r    <= 4'b0000;
      mem_wdata_r <= 32'h0000_0000;
    end else begin
      state_r     <= state_s;
      wait_cnt_r  <= wait_cnt_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      mis_r       <= mis_s;
      tmo_r       <= tmo_s;
      mdr_r       <= mdr_s;
      be_out_r    <= be_out_s;
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_be_r    <= mem_be_s;
      mem_wdata_r <= mem_wdata_s;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign misalign    = mis_r;
  assign timeout_err = tmo_r;
  assign mdr_out     = mdr_r;
  assign be_out      = be_out_r;
  assign mem_req     = mem_req_r;
  assign mem_we      = mem_we_r;
  assign mem_addr    = mem_addr_r;
  assign mem_be      = mem_be_r;
  assign mem_wdata   = mem_wdata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed corner cases plus randomized transactions
// against a transaction-level model (byte counts, lane arithmetic, expected done cycle).
module tb_mem_access_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst, start, mem_ack;
  logic [5:0]  opcode;
  logic [31:0] addr, wdata_in, mem_rdata;
  logic        busy, done, misalign, timeout_err, mem_req, mem_we;
  logic [31:0] mdr_out, mem_wdata;
  logic [3:0]  be_out, mem_be;
  logic [29:0] mem_addr;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state
  logic [31:0] exp_mdr;
  logic [3:0]  exp_beo, exp_mbe;
  logic        exp_we;
  logic [29:0] exp_addr;
  logic [31:0] exp_wd;

  logic [5:0] op_tab [10];

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .addr(addr), .wdata_in(wdata_in),
    .busy(busy), .done(done), .misalign(misalign), .timeout_err(timeout_err),
    .mdr_out(mdr_out), .be_out(be_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic int nbytes(input logic [5:0] op);
    case (op)
      6'h23, 6'h2b:        return 4;
      6'h21, 6'h25, 6'h29: return 2;
      6'h20, 6'h24, 6'h28: return 1;
      default:             return 0;
    endcase
  endfunction

  function automatic bit is_st(input logic [5:0] op);
    return (op == 6'h28) || (op == 6'h29) || (op == 6'h2b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_iface(input string pfx);
    check_val({pfx, "_we"}, mem_we, exp_we);
    check_val({pfx, "_addr"}, mem_addr, exp_addr);
    check_val({pfx, "_be"}, mem_be, exp_mbe);
    check_val({pfx, "_wdata"}, mem_wdata, exp_wd);
  endtask

  // One start pulse and the full life of the resulting transaction.
  // ack_at: cycle (req goes high in cycle 1) at which mem_ack is driven.
  task automatic do_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] rd, input bit poke);
    int n, done_cyc, tmp;
    bit acked;
    logic [3:0] be_e;
    logic [31:0] wd_e;
    n = nbytes(op);
    start = 1'b1; opcode = op; addr = a; wdata_in = wd; mem_ack = 1'b0;
    tick();
    start = 1'b0;
    if (n == 0) begin
      check_val("ign_busy", busy, 0);
      check_val("ign_done", done, 0);
      check_val("ign_req", mem_req, 0);
      check_iface("ign");
      tick();
      check_val("ign_done2", done, 0);
    end else if ((int'(a[1:0]) % n) != 0) begin
      if (poke) begin
        start = 1'b1; opcode = 6'h23; addr = 32'h0;
      end
      check_val("mis_done", done, 1);
      check_val("mis_flag", misalign, 1);
      check_val("mis_tmo", timeout_err, 0);
      check_val("mis_busy", busy, 1);
      check_val("mis_req", mem_req, 0);
      check_val("mis_mdr", mdr_out, exp_mdr);
      check_val("mis_beo", be_out, exp_beo);
      tick();
      start = 1'b0;
      check_val("mis_done2", done, 0);
      check_val("mis_flag2", misalign, 0);
      check_val("mis_busy2", busy, 0);
      check_val("mis_req2", mem_req, 0);
    end else begin
      tmp = ((1 << n) - 1) << a[1:0];
      be_e = tmp[3:0];
      for (int i = 0; i < 4; i++) wd_e[8*i +: 8] = wd[8*(i % n) +: 8];
      exp_we = is_st(op); exp_addr = a[31:2]; exp_mbe = be_e; exp_wd = wd_e;
      acked = (ack_at <= TO);
      done_cyc = acked ? ack_at + 1 : TO + 1;
      for (int c = 1; c < done_cyc; c++) begin
        check_val("req_req", mem_req, 1);
        check_val("req_busy", busy, 1);
        check_val("req_done", done, 0);
        check_iface("req");
        mem_ack = (c == ack_at);
        mem_rdata = (c == ack_at) ? rd : $urandom;
        if (poke && c == 1) begin
          start = 1'b1; opcode = 6'h2b; addr = $urandom; wdata_in = $urandom;
        end
        tick();
        start = 1'b0; mem_ack = 1'b0;
      end
      if (acked && !is_st(op)) begin
        exp_mdr = rd; exp_beo = be_e;
      end
      check_val("fin_done", done, 1);
      check_val("fin_tmo", timeout_err, !acked);
      check_val("fin_mis", misalign, 0);
      check_val("fin_req", mem_req, 0);
      check_val("fin_busy", busy, 1);
      check_val("fin_mdr", mdr_out, exp_mdr);
      check_val("fin_beo", be_out, exp_beo);
      mem_ack = (ack_at == done_cyc) || ($urandom_range(0, 1) == 1);
      mem_rdata = $urandom;
      tick();
      mem_ack = 1'b0;
      check_val("post_done", done, 0);
      check_val("post_tmo", timeout_err, 0);
      check_val("post_busy", busy, 0);
      check_val("post_mdr", mdr_out, exp_mdr);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    op_tab = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b, 6'h00, 6'h0f};
    rst = 1'b0; start = 1'b0; mem_ack = 1'b0; opcode = 6'h0; addr = 32'h0;
    wdata_in = 32'h0; mem_rdata = 32'h0;
    exp_mdr = 32'h0; exp_beo = 4'h0; exp_mbe = 4'h0; exp_we = 1'b0; exp_addr = 30'h0; exp_wd = 32'h0;
    tick(); tick();
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_req", mem_req, 0);
    check_val("rst_mdr", mdr_out, 0);
    check_val("rst_beo", be_out, 0);
    check_iface("rst");
    rst = 1'b1;
    tick();

    // Directed corner cases
    do_txn(6'h23, 32'h0000_0104, 32'h1234_5678, 3, 32'hDEAD_BEEF, 1'b0);
    check_val("lw_mdr", mdr_out, 32'hDEAD_BEEF);
    do_txn(6'h28, 32'h0000_0013, 32'h0000_00A5, 2, 32'h5555_5555, 1'b0);
    check_val("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    check_val("sb_be", mem_be, 4'b1000);
    do_txn(6'h21, 32'h0000_0101, 32'h0, 1, 32'h0, 1'b0);
    do_txn(6'h2b, 32'h0000_0102, 32'h0, 1, 32'h0, 1'b1);
    do_txn(6'h20, 32'h0000_0101, 32'h0, 1, 32'h0102_0304, 1'b0);
    check_val("lb_be", mem_be, 4'b0010);
    do_txn(6'h23, 32'h0000_0200, 32'h0, 1000, 32'h0, 1'b0);
    do_txn(6'h25, 32'h0000_0302, 32'h0, TO, 32'hCAFE_F00D, 1'b1);
    do_txn(6'h23, 32'h0000_0400, 32'h0, TO + 1, 32'h1111_2222, 1'b0);
    do_txn(6'h00, 32'h0000_0500, 32'h0, 1, 32'h0, 1'b0);

    // Reset in the middle of a request; a late ack afterwards must be ignored
    start = 1'b1; opcode = 6'h23; addr = 32'h0000_0600;
    tick();
    start = 1'b0;
    check_val("mr_req", mem_req, 1);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_mdr = 32'h0; exp_beo = 4'h0; exp_mbe = 4'h0; exp_we = 1'b0; exp_addr = 30'h0; exp_wd = 32'h0;
    check_val("mr_req0", mem_req, 0);
    check_val("mr_busy0", busy, 0);
    check_val("mr_mdr0", mdr_out, 0);
    check_val("mr_done0", done, 0);
    check_iface("mr");
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_ack = 1'b0;
    check_val("mr_done1", done, 0);
    check_val("mr_mdr1", mdr_out, 0);
    tick();
    check_val("mr_done2", done, 0);

    // Randomized transactions
    for (int t = 0; t < 80; t++) begin
      logic [5:0] op;
      int ack_at;
      op = op_tab[$urandom_range(0, 9)];
      ack_at = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(1, 4);
      do_txn(op, $urandom, $urandom, ack_at, $urandom, ($urandom_range(0, 3) == 0));
      mem_ack = $urandom_range(0, 1) == 1;
      tick();
      mem_ack = 1'b0;
      check_val("gap_done", done, 0);
      check_val("gap_busy", busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
